// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the MEM-stage load/store unit: access-size
// encodings, the controller state type and small size/alignment helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      LDX,
      MERGE,
      WR,
      RESP
   } state_t;

   // Access size in bytes: 1, 2, 4 or 8.
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

   // An access must start on a multiple of its own size.
   function automatic logic is_misaligned(input logic [2:0] offset, input logic [1:0] size);
      case (size)
         SZ_HALF:  return offset[0];
         SZ_WORD:  return |offset[1:0];
         SZ_DWORD: return |offset;
         default:  return 1'b0;
      endcase
   endfunction

   // Right-justified all-ones mask covering one access of the given size.
   function automatic logic [63:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_BYTE: return 64'h0000_0000_0000_00FF;
         SZ_HALF: return 64'h0000_0000_0000_FFFF;
         SZ_WORD: return 64'h0000_0000_FFFF_FFFF;
         default: return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering between a 64-bit memory doubleword and a
// right-justified 1/2/4/8-byte operand.
//   dword     : doubleword read from memory
//   offset    : byte offset of the access inside the doubleword
//   size      : access size encoding (SZ_*)
//   sign_ext  : sign-extend the loaded lane (ignored for dwords)
//   wdata     : right-justified store operand
//   load_data : extracted and extended load result
//   merged    : dword with the addressed lane replaced by wdata
// ---------------------------------------------------------------------------
module mem_lane_align
   import mem_access_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic [63:0] dword,
   input  logic [2:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [63:0] wdata,
   output logic [63:0] load_data,
   output logic [63:0] merged
);

   logic [2:0]  lane;
   logic [5:0]  shift;
   logic [63:0] mask;
   logic [63:0] lane_bits;

   // NOTE: every signal assigned here gets a value on every path before any
   // conditional override, so no latch can be inferred.
   always_comb begin
      lane = offset;
      // Big-endian puts byte offset 0 in the top byte, so the lane sits
      // (8 - size - offset) bytes above bit 0.
      if (BIG_ENDIAN) begin
         lane = 3'(4'd8 - size_bytes(size) - {1'b0, offset});
      end
      shift     = {lane, 3'b000};
      mask      = size_mask(size);
      lane_bits = (dword >> shift) & mask;

      load_data = lane_bits;
      if (sign_ext) begin
         case (size)
            SZ_BYTE: load_data = {{56{lane_bits[7]}},  lane_bits[7:0]};
            SZ_HALF: load_data = {{48{lane_bits[15]}}, lane_bits[15:0]};
            SZ_WORD: load_data = {{32{lane_bits[31]}}, lane_bits[31:0]};
            default: load_data = lane_bits;
         endcase
      end

      merged = (dword & ~(mask << shift)) | ((wdata & mask) << shift);
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Initiator side of the CustMem interface for the MEM stage. Takes one
// load/store at a time, issues doubleword-indexed memory requests (with
// read-modify-write for sub-doubleword stores) and returns extended load
// data with a one-cycle completion pulse.
//   p_clk, p_reset            : clock, synchronous active-high reset
//   p_reqValid/p_reqReady     : command handshake (ready only in IDLE)
//   p_reqWrite/Size/Signed    : command type, size encoding, load extension
//   p_reqAddr/p_reqWData      : byte address, right-justified store data
//   p_rspValid/Data/Misaligned: completion pulse, load result, alignment error
//   p_memReadRequest/WriteRequest/Address/WriteData : memory request side
//   p_memReadData/p_memWait   : memory read data (cycle after accept), stall
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic        p_clk,
   input  logic        p_reset,
   input  logic        p_reqValid,
   output logic        p_reqReady,
   input  logic        p_reqWrite,
   input  logic [1:0]  p_reqSize,
   input  logic        p_reqSigned,
   input  logic [63:0] p_reqAddr,
   input  logic [63:0] p_reqWData,
   output logic        p_rspValid,
   output logic [63:0] p_rspData,
   output logic        p_rspMisaligned,
   output logic        p_memReadRequest,
   output logic        p_memWriteRequest,
   output logic [63:0] p_memAddress,
   output logic [63:0] p_memWriteData,
   input  logic [63:0] p_memReadData,
   input  logic        p_memWait
);

   state_t      state;
   logic [2:0]  cmd_offset;
   logic [1:0]  cmd_size;
   logic        cmd_signed;
   logic        cmd_write;
   logic [63:0] cmd_wdata;
   logic [63:0] load_data;
   logic [63:0] merged;

   assign p_reqReady = !p_reset && (state == IDLE);

   // Read data is consumed in LDX/MERGE, the cycle after the read accept.
   mem_lane_align #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_align (
      .dword     (p_memReadData),
      .offset    (cmd_offset),
      .size      (cmd_size),
      .sign_ext  (cmd_signed),
      .wdata     (cmd_wdata),
      .load_data (load_data),
      .merged    (merged)
   );

   // NOTE: state and registered outputs use non-blocking assignments so every
   // read in this block sees the pre-edge value.
   always_ff @(posedge p_clk) begin
      if (p_reset) begin
         state             <= IDLE;
         cmd_offset        <= '0;
         cmd_size          <= SZ_BYTE;
         cmd_signed        <= 1'b0;
         cmd_write         <= 1'b0;
         cmd_wdata         <= '0;
         p_rspValid        <= 1'b0;
         p_rspData         <= '0;
         p_rspMisaligned   <= 1'b0;
         p_memReadRequest  <= 1'b0;
         p_memWriteRequest <= 1'b0;
         p_memAddress      <= '0;
         p_memWriteData    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (p_reqValid && p_reqReady) begin
                  cmd_offset   <= p_reqAddr[2:0];
                  cmd_size     <= p_reqSize;
                  cmd_signed   <= p_reqSigned;
                  cmd_write    <= p_reqWrite;
                  cmd_wdata    <= p_reqWData;
                  // Set once here and held through RD/MERGE/WR.
                  p_memAddress <= {3'b000, p_reqAddr[63:3]};
                  if (is_misaligned(p_reqAddr[2:0], p_reqSize)) begin
                     p_rspValid      <= 1'b1;
                     p_rspMisaligned <= 1'b1;
                     p_rspData       <= '0;
                     state           <= RESP;
                  end else if (p_reqWrite && (p_reqSize == SZ_DWORD)) begin
                     // Whole-doubleword store needs no read-modify-write.
                     p_memWriteData    <= p_reqWData;
                     p_memWriteRequest <= 1'b1;
                     state             <= WR;
                  end else begin
                     p_memReadRequest <= 1'b1;
                     state            <= RD;
                  end
               end
            end
            RD: begin
               if (!p_memWait) begin
                  p_memReadRequest <= 1'b0;
                  state            <= cmd_write ? MERGE : LDX;
               end
            end
            LDX: begin
               p_rspData  <= load_data;
               p_rspValid <= 1'b1;
               state      <= RESP;
            end
            MERGE: begin
               p_memWriteData    <= merged;
               p_memWriteRequest <= 1'b1;
               state             <= WR;
            end
            WR: begin
               if (!p_memWait) begin
                  p_memWriteRequest <= 1'b0;
                  p_rspValid        <= 1'b1;
                  p_rspData         <= '0;
                  state             <= RESP;
               end
            end
            RESP: begin
               p_rspValid      <= 1'b0;
               p_rspMisaligned <= 1'b0;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Drives a little-endian and a big-endian instance with identical commands.
// Each instance has its own doubleword memory responder; expected values come
// from a byte-addressed reference memory per endianness.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        p_clk = 1'b0;
   logic        p_reset;
   logic        req_valid;
   logic        req_write;
   logic        req_signed;
   logic [1:0]  req_size;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        mem_wait;

   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_mis;
   logic [1:0]  rd_req;
   logic [1:0]  wr_req;
   logic [63:0] rsp_data [2];
   logic [63:0] mem_addr [2];
   logic [63:0] wr_data  [2];
   logic [63:0] rd_data  [2];

   // Memory responders (index 0 = little-endian DUT, 1 = big-endian DUT).
   logic [63:0] mem [2][16];
   logic        poke_en;
   logic [3:0]  poke_idx;
   logic [63:0] poke_val [2];

   // Reference: byte-addressed memory image as each DUT's program sees it.
   logic [7:0]  ref_b [2][128];

   int n_cmp = 0;
   int n_err = 0;

   always #5 p_clk = ~p_clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_access_unit #(
         .BIG_ENDIAN (g == 1)
      ) dut (
         .p_clk             (p_clk),
         .p_reset           (p_reset),
         .p_reqValid        (req_valid),
         .p_reqReady        (req_ready[g]),
         .p_reqWrite        (req_write),
         .p_reqSize         (req_size),
         .p_reqSigned       (req_signed),
         .p_reqAddr         (req_addr),
         .p_reqWData        (req_wdata),
         .p_rspValid        (rsp_valid[g]),
         .p_rspData         (rsp_data[g]),
         .p_rspMisaligned   (rsp_mis[g]),
         .p_memReadRequest  (rd_req[g]),
         .p_memWriteRequest (wr_req[g]),
         .p_memAddress      (mem_addr[g]),
         .p_memWriteData    (wr_data[g]),
         .p_memReadData     (rd_data[g]),
         .p_memWait         (mem_wait)
      );
   end

   // Memory: read data valid only in the cycle after an accepted read,
   // random junk otherwise.
   always @(posedge p_clk) begin
      for (int d = 0; d < 2; d++) begin
         rd_data[d] <= {$urandom, $urandom};
         if (poke_en) begin
            mem[d][poke_idx] <= poke_val[d];
         end else begin
            if (rd_req[d] && !mem_wait) rd_data[d] <= mem[d][mem_addr[d][3:0]];
            if (wr_req[d] && !mem_wait) mem[d][mem_addr[d][3:0]] <= wr_data[d];
         end
      end
   end

   task automatic cyc();
      @(posedge p_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] dword_of(input int d, input int idx);
      logic [63:0] v = '0;
      for (int k = 0; k < 8; k++)
         v |= 64'(ref_b[d][8*idx+k]) << (d == 0 ? 8*k : 8*(7-k));
      return v;
   endfunction

   function automatic logic [63:0] model_load(input int d, input logic [63:0] a, input int s, input bit sg);
      logic [63:0] v = '0;
      int base = int'(a[6:0]);
      for (int j = 0; j < s; j++)
         v |= 64'(ref_b[d][base+j]) << (d == 0 ? 8*j : 8*(s-1-j));
      if (sg && s < 8 && v[8*s-1]) v |= ~((64'd1 << (8*s)) - 64'd1);
      return v;
   endfunction

   task automatic model_store(input int d, input logic [63:0] a, input int s, input logic [63:0] wd);
      int base = int'(a[6:0]);
      for (int j = 0; j < s; j++)
         ref_b[d][base+j] = 8'(wd >> (d == 0 ? 8*j : 8*(s-1-j)));
   endtask

   task automatic preload(input int idx, input logic [63:0] v);
      poke_en     = 1'b1;
      poke_idx    = 4'(idx);
      poke_val[0] = v;
      poke_val[1] = v;
      for (int k = 0; k < 8; k++) begin
         ref_b[0][8*idx+k] = v[8*k +: 8];
         ref_b[1][8*idx+k] = v[8*(7-k) +: 8];
      end
      cyc();
      poke_en = 1'b0;
   endtask

   // One command end to end: latency, strobes, address, response and memory.
   task automatic run_cmd(input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input int wait_first, input int rand_pct,
                          output int rd_cyc, output int wr_cyc);
      int s, lat, stalls, exp_lat, idx;
      bit seen, mis, both, bad_addr, busy_ready;
      logic [63:0] exp_data [2];
      s = 1 << sz;
      mis = (addr[2:0] & 3'(s - 1)) != 3'd0;
      idx = int'(addr[6:3]);
      lat = 0; stalls = 0; rd_cyc = 0; wr_cyc = 0;
      seen = 0; both = 0; bad_addr = 0; busy_ready = 0;

      for (int i = 0; i < 20 && req_ready != 2'b11; i++) cyc();
      check("ready_before_cmd", 64'(req_ready), 64'h3);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
      req_addr = addr; req_wdata = wd; mem_wait = 1'b0;
      cyc();
      // Scramble inputs: the unit must work from its captured copy.
      req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
      req_signed = 1'($urandom); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};

      for (int d = 0; d < 2; d++) begin
         exp_data[d] = (mis || wr) ? 64'd0 : model_load(d, addr, s, sg);
         if (wr && !mis) model_store(d, addr, s, wd);
      end

      for (int k = 1; k <= 40; k++) begin
         if (rsp_valid[0]) begin
            seen = 1; lat = k;
            break;
         end
         if (req_ready != 2'b00) busy_ready = 1;
         mem_wait = (k <= wait_first) || ($urandom_range(0, 99) < rand_pct);
         for (int d = 0; d < 2; d++) begin
            if (rd_req[d] && wr_req[d]) both = 1;
            if ((rd_req[d] || wr_req[d]) && mem_addr[d] !== {3'b000, addr[63:3]}) bad_addr = 1;
         end
         rd_cyc += int'(rd_req[0]);
         wr_cyc += int'(wr_req[0]);
         if ((rd_req[0] || wr_req[0]) && mem_wait) stalls++;
         cyc();
      end

      exp_lat = (mis ? 1 : !wr ? 3 : (sz == 2'd3) ? 2 : 4) + stalls;
      check("rsp_seen", 64'(seen), 64'd1);
      check("latency", 64'(lat), 64'(exp_lat));
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rsp_valid[%0d]", d), 64'(rsp_valid[d]), 64'd1);
         check($sformatf("rsp_mis[%0d]", d), 64'(rsp_mis[d]), 64'(mis));
         check($sformatf("rsp_data[%0d]", d), rsp_data[d], exp_data[d]);
      end
      check("read_issued", 64'(rd_cyc != 0), 64'(!mis && !(wr && sz == 2'd3)));
      check("write_issued", 64'(wr_cyc != 0), 64'(!mis && wr));
      check("strobe_overlap", 64'(both), 64'd0);
      check("mem_addr_ok", 64'(bad_addr), 64'd0);
      check("ready_while_busy", 64'(busy_ready), 64'd0);

      mem_wait = 1'b0;
      cyc();
      check("rsp_pulse_end", 64'(rsp_valid), 64'd0);
      check("ready_after_resp", 64'(req_ready), 64'h3);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rsp_data_hold[%0d]", d), rsp_data[d], exp_data[d]);
         if (wr) check($sformatf("mem_dword[%0d]", d), mem[d][idx], dword_of(d, idx));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rc, wc, n_rsp, ready_k, ready_cnt;
      int rsp_k [2];
      logic [63:0] a;
      logic [1:0]  sz;
      logic [63:0] exp_a [2];
      logic [63:0] exp_b [2];

      p_reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0; mem_wait = 1'b0; poke_en = 1'b0;
      for (int i = 0; i < 16; i++) preload(i, {$urandom, $urandom});

      // Reset state.
      check("reset_ready", 64'(req_ready), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_mis", 64'(rsp_mis), 64'd0);
      check("reset_strobes", 64'({rd_req, wr_req}), 64'd0);
      for (int d = 0; d < 2; d++) begin
         check("reset_rsp_data", rsp_data[d], 64'd0);
         check("reset_mem_addr", mem_addr[d], 64'd0);
         check("reset_wr_data", wr_data[d], 64'd0);
      end
      p_reset = 1'b0;
      cyc();
      check("ready_after_reset", 64'(req_ready), 64'h3);

      // Signed / unsigned byte load.
      preload(2, 64'h1122_3344_8877_6655);
      run_cmd(1'b0, 2'd0, 1'b1, 64'h13, 64'd0, 0, 0, rc, wc);
      check("lb_signed_const", rsp_data[0], 64'hFFFF_FFFF_FFFF_FF88);
      check("lb_signed_addr", mem_addr[0], 64'd2);
      run_cmd(1'b0, 2'd0, 1'b0, 64'h13, 64'd0, 0, 0, rc, wc);
      check("lb_unsigned_const", rsp_data[0], 64'h0000_0000_0000_0088);

      // Half store with read-modify-write.
      preload(2, 64'h1122_3344_5566_7788);
      run_cmd(1'b1, 2'd1, 1'b0, 64'h16, 64'h1234_5678_9ABC_BEEF, 0, 0, rc, wc);
      check("sh_le_const", mem[0][2], 64'hBEEF_3344_5566_7788);
      check("sh_be_const", mem[1][2], 64'h1122_3344_5566_BEEF);

      // Dword store with three stall cycles.
      run_cmd(1'b1, 2'd3, 1'b0, 64'h40, 64'hDEAD_BEEF_CAFE_F00D, 3, 0, rc, wc);
      check("sd_write_cycles", 64'(wc), 64'd4);
      check("sd_read_cycles", 64'(rc), 64'd0);
      check("sd_mem_const", mem[0][8], 64'hDEAD_BEEF_CAFE_F00D);

      // Misaligned word load.
      run_cmd(1'b0, 2'd2, 1'b0, 64'h06, 64'd0, 0, 0, rc, wc);

      // Reset while stalled in RD.
      for (int i = 0; i < 20 && req_ready != 2'b11; i++) cyc();
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_addr = 64'h18; mem_wait = 1'b1;
      cyc();
      req_valid = 1'b0;
      check("rst_rd_active", 64'(rd_req), 64'h3);
      cyc();
      p_reset = 1'b1;
      cyc();
      check("rst_strobes", 64'({rd_req, wr_req}), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_ready_low", 64'(req_ready), 64'd0);
      p_reset = 1'b0; mem_wait = 1'b0;
      cyc();
      check("rst_ready_back", 64'(req_ready), 64'h3);
      check("rst_no_rsp", 64'(rsp_valid), 64'd0);
      run_cmd(1'b0, 2'd3, 1'b0, 64'h0, 64'd0, 0, 0, rc, wc);

      // Back-to-back loads with reqValid held high.
      for (int i = 0; i < 20 && req_ready != 2'b11; i++) cyc();
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 64'h20; mem_wait = 1'b0;
      cyc();
      for (int d = 0; d < 2; d++) begin
         exp_a[d] = model_load(d, 64'h20, 4, 1'b0);
         exp_b[d] = model_load(d, 64'h32, 2, 1'b1);
      end
      req_size = 2'd1; req_signed = 1'b1; req_addr = 64'h32;
      n_rsp = 0; ready_k = 0; ready_cnt = 0; rsp_k[0] = 0; rsp_k[1] = 0;
      for (int k = 1; k <= 10; k++) begin
         if (rsp_valid[0]) begin
            if (n_rsp < 2) rsp_k[n_rsp] = k;
            for (int d = 0; d < 2; d++)
               check($sformatf("b2b_data%0d[%0d]", n_rsp, d), rsp_data[d], n_rsp == 0 ? exp_a[d] : exp_b[d]);
            n_rsp++;
         end
         if (req_ready[0] && k <= 7) ready_cnt++;
         if (req_ready[0] && ready_k == 0) ready_k = k;
         cyc();
         if (k == ready_k) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      check("b2b_rsp_count", 64'(n_rsp), 64'd2);
      check("b2b_first_rsp", 64'(rsp_k[0]), 64'd3);
      check("b2b_ready_cycle", 64'(ready_k), 64'd4);
      check("b2b_second_rsp", 64'(rsp_k[1]), 64'd7);
      check("b2b_ready_count", 64'(ready_cnt), 64'd1);

      // Random commands with random stalls.
      for (int t = 0; t < 60; t++) begin
         sz = 2'($urandom_range(0, 3));
         a = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) a[63:7] = '0;
         if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
         run_cmd(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, 0, 30, rc, wc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
